// File: rtl/dpmem_pkg.sv
// dpmem_pkg
//   Shared constants and helpers for the byte-enable dual-port memory.
//   - RDW_OLD / RDW_NEW : read-during-write collision modes
//   - lane_count()      : number of byte lanes in a word
//   - lane_parity()     : per-lane even-parity vector of a data word
//   Parity helpers are only used when DPMEM_PARITY_EN is defined.
package dpmem_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Upper bounds for the generic parity helper. Callers widen their word to
  // MAX_DATA bits and take the low lane_count() bits of the result.
  localparam int MAX_DATA  = 512;
  localparam int MAX_LANES = 64;

  function automatic int lane_count(input int data_size, input int byte_size);
    return data_size / byte_size;
  endfunction

  // Even parity per lane: bit l is the XOR of lane l's data bits, so that
  // data plus parity bit always carries an even number of ones.
  function automatic logic [MAX_LANES-1:0] lane_parity(
    input logic [MAX_DATA-1:0] word,
    input int                  byte_size,
    input int                  lanes
  );
    logic [MAX_LANES-1:0] par;
    par = '0;
    for (int b = 0; b < MAX_DATA; b++) begin
      if (b < lanes * byte_size) begin
        par[6'(b / byte_size)] = par[6'(b / byte_size)] ^ word[9'(b)];
      end
    end
    return par;
  endfunction

endpackage

// File: rtl/dpmem_be_if.sv
// dpmem_be_if
//   Write/read port bundle of the byte-enable dual-port memory.
//   master : the user of the memory (drives writes and read requests)
//   slave  : the memory itself
//   Signals: dat_in, wr_adr, wr_en, wr_be, rd_adr, rd_en -> memory
//            dat_out, rd_valid (and parity_err with DPMEM_PARITY_EN) <- memory
interface dpmem_be_if #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 10,
  parameter int BYTE_SIZE = 8
);
  import dpmem_pkg::*;

  localparam int LANES = lane_count(DATA_SIZE, BYTE_SIZE);

  logic [DATA_SIZE-1:0] dat_in;
  logic [ADDR_SIZE-1:0] wr_adr;
  logic                 wr_en;
  logic [LANES-1:0]     wr_be;
  logic [ADDR_SIZE-1:0] rd_adr;
  logic                 rd_en;
  logic [DATA_SIZE-1:0] dat_out;
  logic                 rd_valid;
`ifdef DPMEM_PARITY_EN
  logic                 parity_err;
`endif

  modport master (
    output dat_in, wr_adr, wr_en, wr_be, rd_adr, rd_en,
    input  dat_out, rd_valid
`ifdef DPMEM_PARITY_EN
    , input parity_err
`endif
  );

  modport slave (
    input  dat_in, wr_adr, wr_en, wr_be, rd_adr, rd_en,
    output dat_out, rd_valid
`ifdef DPMEM_PARITY_EN
    , output parity_err
`endif
  );

endinterface

// File: rtl/dpmem_rd_pipe.sv
// dpmem_rd_pipe
//   Read side of dpmem_be: valid/data pipeline (1 or 2 stages), the
//   read-during-write merge mux and, with DPMEM_PARITY_EN, the parity check.
//   Ports:
//     clk, reset   clock and synchronous active-high reset
//     rd_en        read request sampled this edge
//     collision    write to the same address in the same cycle as rd_en
//     wr_be        byte-lane enables of that write
//     wr_word      write word in storage layout (lane-interleaved)
//     rd_word      registered RAM output (word as stored before the write)
//     dat_out      read data, holds when no read completes, 0 after reset
//     rd_valid     one strobe per accepted read
//     parity_err   (DPMEM_PARITY_EN only) lane parity mismatch, with rd_valid
module dpmem_rd_pipe
  import dpmem_pkg::*;
#(
  parameter int DATA_SIZE  = 32,
  parameter int BYTE_SIZE  = 8,
  parameter int LANES      = 4,
  parameter int LANE_W     = 8,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = RDW_OLD
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rd_en,
  input  logic                      collision,
  input  logic [LANES-1:0]          wr_be,
  input  logic [LANES*LANE_W-1:0]   wr_word,
  input  logic [LANES*LANE_W-1:0]   rd_word,
  output logic [DATA_SIZE-1:0]      dat_out,
  output logic                      rd_valid
`ifdef DPMEM_PARITY_EN
  , output logic                    parity_err
`endif
);

  localparam int STORE_W = LANES * LANE_W;

  logic               v1_reg;
  logic [LANES-1:0]   col_be_reg;   // lanes to take from the colliding write
  logic [STORE_W-1:0] wr_word_reg;
  logic [STORE_W-1:0] merged;
  logic [DATA_SIZE-1:0] data1;

  // The RAM read register already holds the pre-write word. For the
  // "new data" mode the colliding write is captured next to it and the
  // enabled lanes are substituted after the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_reg     <= 1'b0;
      col_be_reg <= '0;
    end else begin
      v1_reg <= rd_en;
      if (rd_en) begin
        col_be_reg  <= (RDW_MODE == RDW_NEW && collision) ? wr_be : '0;
        wr_word_reg <= wr_word;
      end
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign merged[gi*LANE_W +: LANE_W] = col_be_reg[gi] ? wr_word_reg[gi*LANE_W +: LANE_W]
                                                        : rd_word[gi*LANE_W +: LANE_W];
    assign data1[gi*BYTE_SIZE +: BYTE_SIZE] = merged[gi*LANE_W +: BYTE_SIZE];
  end

`ifdef DPMEM_PARITY_EN
  logic [LANES-1:0]     stored_par;
  logic [MAX_LANES-1:0] calc_par;
  logic                 perr1;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_par
    assign stored_par[gi] = merged[gi*LANE_W + BYTE_SIZE];
  end
  assign calc_par = lane_parity(MAX_DATA'(data1), BYTE_SIZE, LANES);
  assign perr1    = v1_reg && ((stored_par ^ calc_par[LANES-1:0]) != '0);
`endif

  if (RD_LATENCY == 1) begin : g_lat1
    // The RAM output register is not reset, so the output is forced to
    // zero from reset until the first read lands in it.
    logic hold_zero_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        hold_zero_reg <= 1'b1;
      end else if (rd_en) begin
        hold_zero_reg <= 1'b0;
      end
    end

    assign dat_out  = hold_zero_reg ? '0 : data1;
    assign rd_valid = v1_reg;
`ifdef DPMEM_PARITY_EN
    assign parity_err = perr1;
`endif
  end else begin : g_lat2
    logic [DATA_SIZE-1:0] dat2_reg;
    logic                 v2_reg;
`ifdef DPMEM_PARITY_EN
    logic                 perr2_reg;
`endif

    always_ff @(posedge clk) begin
      if (reset) begin
        dat2_reg  <= '0;
        v2_reg    <= 1'b0;
`ifdef DPMEM_PARITY_EN
        perr2_reg <= 1'b0;
`endif
      end else begin
        v2_reg <= v1_reg;
`ifdef DPMEM_PARITY_EN
        perr2_reg <= perr1;
`endif
        if (v1_reg) begin
          dat2_reg <= data1;
        end
      end
    end

    assign dat_out  = dat2_reg;
    assign rd_valid = v2_reg;
`ifdef DPMEM_PARITY_EN
    assign parity_err = perr2_reg;
`endif
  end

endmodule

// File: rtl/dpmem_be.sv
// dpmem_be
//   Simple dual-port synchronous RAM, one write port and one read port on
//   one clock, with per-byte write enables, read valid strobe, selectable
//   read latency (1 or 2) and defined read-during-write behaviour.
//   Ports:
//     clk     rising-edge clock
//     reset   synchronous active-high reset (does not clear the RAM)
//     bus     dpmem_be_if.slave: dat_in, wr_adr, wr_en, wr_be, rd_adr,
//             rd_en in; dat_out, rd_valid (parity_err) out
//   Optional feature: define DPMEM_PARITY_EN to store one even-parity bit
//   per lane and flag mismatches on read through parity_err.
//   Storage keeps each lane's parity bit right above its data byte, so a
//   lane write enable covers data and parity together.
module dpmem_be
  import dpmem_pkg::*;
#(
  parameter int DATA_SIZE  = 32,
  parameter int ADDR_SIZE  = 10,
  parameter int BYTE_SIZE  = 8,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = RDW_OLD
) (
  input logic       clk,
  input logic       reset,
  dpmem_be_if.slave bus
);

  localparam int LANES = lane_count(DATA_SIZE, BYTE_SIZE);
`ifdef DPMEM_PARITY_EN
  localparam int LANE_W = BYTE_SIZE + 1;
`else
  localparam int LANE_W = BYTE_SIZE;
`endif
  localparam int STORE_W = LANES * LANE_W;
  localparam int DEPTH   = 2 ** ADDR_SIZE;

  if (DATA_SIZE % BYTE_SIZE != 0) begin : g_chk_lanes
    $error("dpmem_be: DATA_SIZE (%0d) is not a multiple of BYTE_SIZE (%0d)", DATA_SIZE, BYTE_SIZE);
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_chk_latency
    $error("dpmem_be: RD_LATENCY must be 1 or 2, got %0d", RD_LATENCY);
  end

  logic [STORE_W-1:0] mem [DEPTH];
  logic [STORE_W-1:0] wr_word;
  logic [STORE_W-1:0] rd_word_reg;
  logic               collision;

`ifdef DPMEM_PARITY_EN
  logic [MAX_LANES-1:0] wr_par;
  assign wr_par = lane_parity(MAX_DATA'(bus.dat_in), BYTE_SIZE, LANES);
`endif

  for (genvar gi = 0; gi < LANES; gi++) begin : g_wr_lane
    assign wr_word[gi*LANE_W +: BYTE_SIZE] = bus.dat_in[gi*BYTE_SIZE +: BYTE_SIZE];
`ifdef DPMEM_PARITY_EN
    assign wr_word[gi*LANE_W + BYTE_SIZE] = wr_par[gi];
`endif
  end

  // Byte-lane write; disabled lanes keep their contents.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !reset) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.wr_be[i]) begin
          mem[bus.wr_adr][i*LANE_W +: LANE_W] <= wr_word[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Registered read, read-before-write: a same-address write in this cycle
  // is not visible here; the read pipe merges it when RDW_NEW is selected.
  always_ff @(posedge clk) begin
    if (bus.rd_en) begin
      rd_word_reg <= mem[bus.rd_adr];
    end
  end

  assign collision = bus.wr_en && bus.rd_en && (bus.wr_adr == bus.rd_adr);

  dpmem_rd_pipe #(
    .DATA_SIZE  (DATA_SIZE),
    .BYTE_SIZE  (BYTE_SIZE),
    .LANES      (LANES),
    .LANE_W     (LANE_W),
    .RD_LATENCY (RD_LATENCY),
    .RDW_MODE   (RDW_MODE)
  ) u_rd_pipe (
    .clk        (clk),
    .reset      (reset),
    .rd_en      (bus.rd_en),
    .collision  (collision),
    .wr_be      (bus.wr_be),
    .wr_word    (wr_word),
    .rd_word    (rd_word_reg),
    .dat_out    (bus.dat_out),
    .rd_valid   (bus.rd_valid)
`ifdef DPMEM_PARITY_EN
    , .parity_err (bus.parity_err)
`endif
  );

endmodule

// File: tb/tb_dpmem_be.sv
// tb_dpmem_be
//   Drives the same stimulus into two memories:
//     dut1 : RD_LATENCY=1, RDW_MODE=old
//     dut2 : RD_LATENCY=2, RDW_MODE=new
//   A reference model computes each read's expected word and completion
//   cycle and queues it; a negedge monitor pops and compares on rd_valid.
module tb_dpmem_be;
  import dpmem_pkg::*;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int BW = 8;
  localparam int NL = DW / BW;

  typedef struct {
    int          due;
    logic [DW-1:0] data;
    logic        perr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_perr = 1'b0;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  logic [DW-1:0] model [2**AW];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dpmem_be_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .BYTE_SIZE(BW)) bus1 ();
  dpmem_be_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .BYTE_SIZE(BW)) bus2 ();

  dpmem_be #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .BYTE_SIZE(BW),
             .RD_LATENCY(1), .RDW_MODE(RDW_OLD)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  dpmem_be #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .BYTE_SIZE(BW),
             .RD_LATENCY(2), .RDW_MODE(RDW_NEW)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [NL-1:0] be);
    logic [DW-1:0] r;
    for (int i = 0; i < NL; i++) begin
      r[i*BW +: BW] = be[i] ? new_w[i*BW +: BW] : old_w[i*BW +: BW];
    end
    return r;
  endfunction

  // One clock of stimulus on both memories plus the matching model update.
  task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [NL-1:0] be, input logic re, input logic [AW-1:0] ra,
                       input logic rst);
    logic [DW-1:0] old_w;
    logic [DW-1:0] new_w;
    @(posedge clk);
    #1;
    reset = rst;
    bus1.wr_en = we; bus1.wr_adr = wa; bus1.dat_in = wd; bus1.wr_be = be;
    bus1.rd_en = re; bus1.rd_adr = ra;
    bus2.wr_en = we; bus2.wr_adr = wa; bus2.dat_in = wd; bus2.wr_be = be;
    bus2.rd_en = re; bus2.rd_adr = ra;
    if (rst) begin
      // reads that would complete at or after the reset edge are dropped
      while (q1.size() > 0 && q1[$].due > cyc) void'(q1.pop_back());
      while (q2.size() > 0 && q2[$].due > cyc) void'(q2.pop_back());
    end else begin
      if (re) begin
        old_w = model[ra];
        new_w = (we && wa == ra) ? merge(old_w, wd, be) : old_w;
        q1.push_back('{due: cyc + 1, data: old_w, perr: exp_perr});
        q2.push_back('{due: cyc + 2, data: new_w, perr: exp_perr});
      end
      if (we) model[wa] = merge(model[wa], wd, be);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NL-1:0] be);
    cycle(1'b1, a, d, be, 1'b0, '0, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    cycle(1'b0, '0, '0, '0, 1'b1, a, 1'b0);
  endtask

  // Scoreboard monitor, sampling away from the active edge.
  always @(negedge clk) begin
    if (bus1.rd_valid) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_valid", {31'b0, bus1.rd_valid}, 32'd0);
      end else begin
        e1 = q1.pop_front();
        $display("[%0d] dut1 read data=0x%08h want=0x%08h", cyc, bus1.dat_out, e1.data);
        check("dut1_latency", cyc, e1.due);
        check("dut1_data", bus1.dat_out, e1.data);
`ifdef DPMEM_PARITY_EN
        check("dut1_parity", {31'b0, bus1.parity_err}, {31'b0, e1.perr});
`endif
      end
    end else if (q1.size() > 0 && q1[0].due <= cyc) begin
      check("dut1_missing_valid", {31'b0, bus1.rd_valid}, 32'd1);
      void'(q1.pop_front());
    end

    if (bus2.rd_valid) begin
      if (q2.size() == 0) begin
        check("dut2_unexpected_valid", {31'b0, bus2.rd_valid}, 32'd0);
      end else begin
        e2 = q2.pop_front();
        $display("[%0d] dut2 read data=0x%08h want=0x%08h", cyc, bus2.dat_out, e2.data);
        check("dut2_latency", cyc, e2.due);
        check("dut2_data", bus2.dat_out, e2.data);
`ifdef DPMEM_PARITY_EN
        check("dut2_parity", {31'b0, bus2.parity_err}, {31'b0, e2.perr});
`endif
      end
    end else if (q2.size() > 0 && q2[0].due <= cyc) begin
      check("dut2_missing_valid", {31'b0, bus2.rd_valid}, 32'd1);
      void'(q2.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus1.wr_en = 1'b0; bus1.rd_en = 1'b0; bus1.wr_adr = '0; bus1.rd_adr = '0;
    bus1.dat_in = '0; bus1.wr_be = '0;
    bus2.wr_en = 1'b0; bus2.rd_en = 1'b0; bus2.wr_adr = '0; bus2.rd_adr = '0;
    bus2.dat_in = '0; bus2.wr_be = '0;

    // reset state
    repeat (3) cycle(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    idle(1);
    @(negedge clk);
    check("rst_valid1", {31'b0, bus1.rd_valid}, 32'd0);
    check("rst_dout1", bus1.dat_out, 32'd0);
    check("rst_valid2", {31'b0, bus2.rd_valid}, 32'd0);
    check("rst_dout2", bus2.dat_out, 32'd0);

    // full write then read
    wr(10'h005, 32'hDEADBEEF, 4'hF);
    rd(10'h005);
    idle(3);
    @(negedge clk);
    check("t1_hold1", bus1.dat_out, 32'hDEADBEEF);
    check("t1_hold2", bus2.dat_out, 32'hDEADBEEF);

    // partial write, then write with no lanes enabled
    wr(10'h005, 32'h11223344, 4'b0101);
    rd(10'h005);
    idle(3);
    @(negedge clk);
    check("t2_partial1", bus1.dat_out, 32'hDE22BE44);
    check("t2_partial2", bus2.dat_out, 32'hDE22BE44);
    wr(10'h005, 32'hFFFFFFFF, 4'b0000);
    rd(10'h005);
    idle(3);
    @(negedge clk);
    check("t2_be0_1", bus1.dat_out, 32'hDE22BE44);
    check("t2_be0_2", bus2.dat_out, 32'hDE22BE44);

    // same-address read during write
    wr(10'h007, 32'hAAAAAAAA, 4'hF);
    cycle(1'b1, 10'h007, 32'h55555555, 4'b0011, 1'b1, 10'h007, 1'b0);
    idle(3);
    @(negedge clk);
    check("t3_rdw_old", bus1.dat_out, 32'hAAAAAAAA);
    check("t3_rdw_new", bus2.dat_out, 32'hAAAA5555);
    rd(10'h007);
    idle(3);
    @(negedge clk);
    check("t3_after1", bus1.dat_out, 32'hAAAA5555);
    check("t3_after2", bus2.dat_out, 32'hAAAA5555);

    // back-to-back reads, latency and order checked by the scoreboard
    for (int i = 0; i < 4; i++) wr(AW'(i), 32'h1000_0000 + 32'(i) * 32'h0101_0101, 4'hF);
    for (int i = 0; i < 4; i++) rd(AW'(i));
    idle(4);

    // reset while a read is in flight in the 2-stage pipe
    rd(10'h005);
    cycle(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    cycle(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    idle(1);
    @(negedge clk);
    check("t5_dout1", bus1.dat_out, 32'd0);
    check("t5_dout2", bus2.dat_out, 32'd0);
    check("t5_valid2", {31'b0, bus2.rd_valid}, 32'd0);
    rd(10'h005);
    idle(3);
    @(negedge clk);
    check("t5_kept1", bus1.dat_out, 32'hDE22BE44);
    check("t5_kept2", bus2.dat_out, 32'hDE22BE44);

`ifdef DPMEM_PARITY_EN
    // corrupt one stored data bit behind the write logic's back
    wr(10'h009, 32'h12345678, 4'hF);
    idle(1);
    dut1.mem[9][3] = ~dut1.mem[9][3];
    dut2.mem[9][3] = ~dut2.mem[9][3];
    model[9] = model[9] ^ 32'h0000_0008;
    exp_perr = 1'b1;
    rd(10'h009);
    exp_perr = 1'b0;
    rd(10'h005);
    idle(4);
`endif

    // randomized traffic on a small address window, frequent collisions
    for (int i = 0; i < 8; i++) wr(AW'(i), $urandom, 4'hF);
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
            NL'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 7)), ($urandom_range(0, 49) == 0));
    end
    idle(5);
    @(negedge clk);
    check("drain_q1", q1.size(), 32'd0);
    check("drain_q2", q2.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
